// File: rtl/display7_scan.sv
// display7_scan: multiplexed 7-segment scanner with double-buffered data.
// Ports: clk, rst (sync, high), iData/iDp/iBlank/iLzs captured on iLoad,
// iEnable gates scanning; oSeg/oDp/oAn active-low, oFrame per full scan.
module display7_scan #(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000,
  parameter int HEX_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   iData,
  input  logic                    iLoad,
  input  logic [N_DIGITS-1:0]     iDp,
  input  logic [N_DIGITS-1:0]     iBlank,
  input  logic                    iLzs,
  input  logic                    iEnable,
  output logic [6:0]              oSeg,
  output logic                    oDp,
  output logic [N_DIGITS-1:0]     oAn,
  output logic                    oFrame
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  typedef struct packed {
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic                  lzs;
  } buf_t;

  logic [PW-1:0]       psc_q, psc_d;
  logic [IW-1:0]       idx_q, idx_d;
  buf_t                pend_q, pend_d;
  buf_t                act_q, act_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_q, frame_d;

  buf_t                in_w;
  logic                tick;
  logic                wrap;
  logic [3:0]          nib;
  logic [N_DIGITS-1:0] supp;
  logic                lz;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:  s = 7'b1000000;
      4'd1:  s = 7'b1111001;
      4'd2:  s = 7'b0100100;
      4'd3:  s = 7'b0110000;
      4'd4:  s = 7'b0011001;
      4'd5:  s = 7'b0010010;
      4'd6:  s = 7'b0000010;
      4'd7:  s = 7'b1111000;
      4'd8:  s = 7'b0000000;
      4'd9:  s = 7'b0010000;
      4'd10: s = 7'b0001000;
      4'd11: s = 7'b0000011;
      4'd12: s = 7'b1000110;
      4'd13: s = 7'b0100001;
      4'd14: s = 7'b0000110;
      4'd15: s = 7'b0001110;
    endcase
    if (HEX_MODE == 0 && v > 4'd9) s = 7'b1111111;
    return s;
  endfunction

  assign in_w = '{data: iData, dp: iDp, blank: iBlank, lzs: iLzs};

  always_comb begin
    psc_d  = psc_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    act_d  = act_q;
    tick   = iEnable && (psc_q == PW'(SCAN_DIV - 1));
    wrap   = tick && (idx_q == IW'(N_DIGITS - 1));

    if (iEnable) psc_d = tick ? '0 : psc_q + PW'(1);
    if (tick)    idx_d = wrap ? '0 : idx_q + IW'(1);
    if (iLoad)   pend_d = in_w;
    // a load landing on the wrap bypasses pending
    if (wrap)    act_d = iLoad ? in_w : pend_q;
    frame_d = wrap;

    // suppression flag stays set while all higher nibbles are zero
    lz   = act_q.lzs;
    supp = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (act_q.data[k*4 +: 4] != 4'd0) lz = 1'b0;
      supp[k] = lz;
    end

    nib = act_q.data[{idx_q, 2'b00} +: 4];
    if (act_q.blank[idx_q] || supp[idx_q]) seg_d = 7'b1111111;
    else                                   seg_d = decode(nib);
    dp_d = ~(act_q.dp[idx_q] & ~act_q.blank[idx_q]);
    an_d = iEnable ? ~(N_DIGITS'(1) << idx_q) : '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign oSeg   = seg_q;
  assign oDp    = dp_q;
  assign oAn    = an_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_display7_scan.sv
// tb_display7_scan: directed checks of display7_scan with 4 digits,
// SCAN_DIV=4, hex decode on.
module tb_display7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iData;
  logic        iLoad;
  logic [3:0]  iDp;
  logic [3:0]  iBlank;
  logic        iLzs;
  logic        iEnable;
  logic [6:0]  oSeg;
  logic        oDp;
  logic [3:0]  oAn;
  logic        oFrame;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] an_tab [4];

  always #5 clk = ~clk;

  display7_scan #(
    .N_DIGITS(4),
    .SCAN_DIV(4),
    .HEX_MODE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .iData(iData),
    .iLoad(iLoad),
    .iDp(iDp),
    .iBlank(iBlank),
    .iLzs(iLzs),
    .iEnable(iEnable),
    .oSeg(oSeg),
    .oDp(oDp),
    .oAn(oAn),
    .oFrame(oFrame)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv(input int t);
    while (cyc < t) step();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp,
                      input logic [3:0] bl, input logic lzs);
    iData  = d;
    iDp    = dp;
    iBlank = bl;
    iLzs   = lzs;
    iLoad  = 1'b1;
    step();
    iLoad  = 1'b0;
  endtask

  initial begin
    an_tab[0] = 4'b1110;
    an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011;
    an_tab[3] = 4'b0111;
    rst = 1'b1; iData = '0; iLoad = 1'b0; iDp = '0;
    iBlank = '0; iLzs = 1'b0; iEnable = 1'b1;
    repeat (3) step();
    chk("rst_an",    8'(oAn),    8'b1111);
    chk("rst_seg",   8'(oSeg),   8'b1111111);
    chk("rst_dp",    8'(oDp),    8'd1);
    chk("rst_frame", 8'(oFrame), 8'd0);

    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 32; c++) begin
      step();
      chk("frame", 8'(oFrame), (cyc % 16 == 0) ? 8'd1 : 8'd0);
      if (cyc % 4 == 1) chk("scan_an", 8'(oAn), 8'(an_tab[((cyc-1)/4)%4]));
      if (cyc == 1) chk("post_rst_seg", 8'(oSeg), 8'b1000000);
    end

    // mid-frame load stays pending until the wrap at cycle 48
    load(16'hFA95, 4'b0000, 4'b0000, 1'b0);
    adv(37); chk("hold_d1", 8'(oSeg), 8'b1000000);
    adv(45); chk("hold_d3", 8'(oSeg), 8'b1000000);
    chk("hold_an3", 8'(oAn), 8'b0111);
    adv(49); chk("hex_d0_an", 8'(oAn), 8'b1110);
    chk("hex_d0", 8'(oSeg), 8'b0010010);
    adv(53); chk("hex_d1", 8'(oSeg), 8'b0010000);
    adv(57); chk("hex_d2", 8'(oSeg), 8'b0001000);
    adv(61); chk("hex_d3", 8'(oSeg), 8'b0001110);

    // leading-zero suppression, dp on a suppressed digit
    load(16'h0040, 4'b1000, 4'b0000, 1'b1);
    adv(65); chk("lzs_d0", 8'(oSeg), 8'b1000000);
    chk("lzs_d0_dp", 8'(oDp), 8'd1);
    adv(69); chk("lzs_d1", 8'(oSeg), 8'b0011001);
    adv(73); chk("lzs_d2", 8'(oSeg), 8'b1111111);
    adv(77); chk("lzs_d3", 8'(oSeg), 8'b1111111);
    chk("lzs_d3_dp", 8'(oDp), 8'd0);

    // load sampled on the wrap edge at cycle 80
    adv(79);
    load(16'h0007, 4'b0000, 4'b0000, 1'b0);
    adv(81); chk("wrapld_d0", 8'(oSeg), 8'b1111000);
    adv(85); chk("wrapld_d1", 8'(oSeg), 8'b1000000);
    adv(97); chk("wrapld_pend", 8'(oSeg), 8'b1111000);

    // blank overrides segments and dp, anode still selected
    load(16'h0007, 4'b0001, 4'b0001, 1'b0);
    adv(113); chk("blank_an", 8'(oAn), 8'b1110);
    chk("blank_seg", 8'(oSeg), 8'b1111111);
    chk("blank_dp", 8'(oDp), 8'd1);

    // enable drop mid-digit for 10 cycles
    adv(114);
    iEnable = 1'b0;
    step(); chk("dis_an0", 8'(oAn), 8'b1111);
    chk("dis_frame", 8'(oFrame), 8'd0);
    adv(124); chk("dis_an9", 8'(oAn), 8'b1111);
    iEnable = 1'b1;
    step(); chk("res_an0", 8'(oAn), 8'b1110);
    step(); chk("res_an1", 8'(oAn), 8'b1110);
    step(); chk("res_an2", 8'(oAn), 8'b1101);

    // reset during digit 2
    adv(131); chk("pre_rst_an", 8'(oAn), 8'b1011);
    rst = 1'b1;
    step();
    chk("mid_rst_an",    8'(oAn),    8'b1111);
    chk("mid_rst_seg",   8'(oSeg),   8'b1111111);
    chk("mid_rst_dp",    8'(oDp),    8'd1);
    chk("mid_rst_frame", 8'(oFrame), 8'd0);
    rst = 1'b0;
    step();
    chk("rel_an",  8'(oAn),  8'b1110);
    chk("rel_seg", 8'(oSeg), 8'b1000000);
    chk("rel_dp",  8'(oDp),  8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
